// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - requester-side controller for a single-port block RAM with read bursts and ready timeout
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_readMem,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              mem_dataReady
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beats_left;
    logic [7:0]        tmo_cnt;

    // Acceptance is decoded from state alone, so a held req_valid cannot reach any output.
    assign req_ready = (state == IDLE);

    // Single FSM: every strobe and response field is registered on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            beats_left  <= '0;
            tmo_cnt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_last    <= 1'b0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            mem_readMem <= 1'b0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        busy        <= 1'b1;
                        cur_addr    <= req_addr;
                        mem_address <= req_addr;
                        if (req_we) begin
                            beats_left <= '0;
                            mem_data   <= req_wdata;
                            mem_wren   <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            beats_left  <= req_len;
                            mem_readMem <= 1'b1;
                            state       <= RD_ISSUE;
                        end
                    end
                end
                WRITE: begin
                    mem_wren  <= 1'b0;
                    mem_data  <= '0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_last  <= 1'b1;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end
                RD_ISSUE: begin
                    mem_readMem <= 1'b0;
                    tmo_cnt     <= '0;
                    state       <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_dataReady) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_out;
                        rsp_last  <= (beats_left == '0);
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (tmo_cnt + 8'd1 == TMO_LIMIT) begin
                            // Give up on the whole burst; the error beat is also the last one.
                            rsp_valid  <= 1'b1;
                            rsp_data   <= '0;
                            rsp_last   <= 1'b1;
                            rsp_err    <= 1'b1;
                            beats_left <= '0;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (beats_left != '0 && !rsp_err) begin
                            cur_addr    <= cur_addr + 1'b1;
                            mem_address <= cur_addr + 1'b1;
                            beats_left  <= beats_left - 1'b1;
                            mem_readMem <= 1'b1;
                            state       <= RD_ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl with a RAM model
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr, req_wdata;
    logic [3:0]  req_len;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_err, busy;
    logic [15:0] rsp_data;
    logic        mem_readMem, mem_wren;
    logic [15:0] mem_address, mem_data;
    logic [15:0] mem_out = 16'h0;
    logic        mem_dataReady = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] ref_mem[logic [15:0]];
    logic [15:0] ram[logic [15:0]];

    bit model_dead = 1'b0;
    bit rand_lat   = 1'b0;
    bit clash      = 1'b0;
    logic        pend = 1'b0;
    int          dly = 0;
    logic [15:0] paddr = 16'h0;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .LEN_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
        .mem_readMem(mem_readMem), .mem_wren(mem_wren),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_out(mem_out), .mem_dataReady(mem_dataReady)
    );

    always #5 clk = ~clk;

    // Power-on contents of never-written RAM words.
    function automatic logic [15:0] fill(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] ram_rd(input logic [15:0] a);
        return ram.exists(a) ? ram[a] : fill(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    // RAM model: writes on wren, one-shot memDataReady pulse 0..3 cycles after a readMem strobe.
    always @(posedge clk) begin : ram_model
        int lat;
        mem_dataReady <= 1'b0;
        if (mem_wren) ram[mem_address] = mem_data;
        if (mem_readMem && !model_dead) begin
            lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
            paddr <= mem_address;
            dly   <= lat;
            if (lat == 0) begin
                mem_dataReady <= 1'b1;
                mem_out       <= ram_rd(mem_address);
            end else begin
                pend <= 1'b1;
            end
        end else if (pend) begin
            if (dly == 1) begin
                mem_dataReady <= 1'b1;
                mem_out       <= ram_rd(paddr);
                pend          <= 1'b0;
            end
            dly <= dly - 1;
        end
    end

    // Strobe exclusivity watchdog.
    always @(posedge clk) begin
        if (mem_wren && mem_readMem) clash <= 1'b1;
        assert (!(mem_wren && mem_readMem)) else $error("FAIL strobe_excl both strobes high at %0t", $time);
    end

    // Presents one request, waits for acceptance, records the expected responses; returns on the negedge after acceptance.
    task automatic send_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                            input logic [3:0] l, input bit hold);
        bit ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_len = l;
        for (int i = 0; i < 500; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept addr=%h got no req_ready within 500 cycles", a);
        end else if (we) begin
            ref_mem[a] = d;
            exp_q.push_back('{d: 16'h0, last: 1'b1});
        end else begin
            for (int i = 0; i <= int'(l); i++)
                exp_q.push_back('{d: ref_rd(a + 16'(i)), last: (i == int'(l))});
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    // Waits for any response and consumes it.
    task automatic ack_rsp();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL ack_wait rsp_valid=0 expected 1 within 40 cycles"); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_len = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_readMem, mem_wren, mem_address, mem_data, rsp_valid, rsp_data, rsp_last, rsp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b wr=%b a=%h d=%h v=%b rd=%h l=%b e=%b busy=%b expected all 0",
                     mem_readMem, mem_wren, mem_address, mem_data, rsp_valid, rsp_data, rsp_last, rsp_err, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release req_ready=%b busy=%b expected 1 0", req_ready, busy);
        end
    endtask

    task automatic test_write_read();
        send_req(1'b1, 16'h0010, 16'hBEEF, 4'd0, 1'b0);
        checks++;
        if (mem_wren !== 1'b1 || mem_readMem !== 1'b0 || mem_address !== 16'h0010 || mem_data !== 16'hBEEF) begin
            errors++; $display("FAIL write_strobe wren=%b rd=%b a=%h d=%h expected 1 0 0010 beef",
                               mem_wren, mem_readMem, mem_address, mem_data);
        end
        @(negedge clk);
        checks++;
        if (mem_wren !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 16'h0 || rsp_last !== 1'b1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL write_ack wren=%b v=%b d=%h l=%b e=%b expected 0 1 0000 1 0",
                               mem_wren, rsp_valid, rsp_data, rsp_last, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL write_done v=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
        end
        send_req(1'b0, 16'h0010, 16'h0, 4'd0, 1'b0);
        checks++;
        if (mem_readMem !== 1'b1 || mem_wren !== 1'b0 || mem_address !== 16'h0010) begin
            errors++; $display("FAIL read_strobe rd=%b wr=%b a=%h expected 1 0 0010", mem_readMem, mem_wren, mem_address);
        end
        @(negedge clk);
        checks++;
        if (mem_readMem !== 1'b0 || rsp_valid !== 1'b0 || mem_address !== 16'h0010) begin
            errors++; $display("FAIL read_wait rd=%b v=%b a=%h expected 0 0 0010", mem_readMem, rsp_valid, mem_address);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_err !== 1'b0 || rsp_last !== 1'b1) begin
            errors++; $display("FAIL read_rsp v=%b d=%h e=%b l=%b expected 1 beef 0 1", rsp_valid, rsp_data, rsp_err, rsp_last);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_burst_wrap();
        logic [15:0] addrs[$];
        beat_t       got[$];
        logic [15:0] ea[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        logic [15:0] ed[3] = '{16'h1111, 16'h2222, 16'h3333};
        send_req(1'b1, 16'hFFFE, 16'h1111, 4'd0, 1'b0); ack_rsp();
        send_req(1'b1, 16'hFFFF, 16'h2222, 4'd0, 1'b0); ack_rsp();
        send_req(1'b1, 16'h0000, 16'h3333, 4'd0, 1'b0); ack_rsp();
        rsp_ready = 1'b1;
        send_req(1'b0, 16'hFFFE, 16'h0, 4'd2, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (mem_readMem) addrs.push_back(mem_address);
            if (rsp_valid && rsp_ready) got.push_back('{d: rsp_data, last: rsp_last});
            if (got.size() == 3) break;
            @(negedge clk);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (addrs.size() != 3 || got.size() != 3) begin
            errors++; $display("FAIL burst_count strobes=%0d beats=%0d expected 3 3", addrs.size(), got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (addrs[i] !== ea[i] || got[i].d !== ed[i] || got[i].last !== (i == 2)) begin
                    errors++; $display("FAIL burst_beat%0d a=%h d=%h l=%b expected %h %h %b",
                                       i, addrs[i], got[i].d, got[i].last, ea[i], ed[i], i == 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d0;
        logic        l0;
        rsp_ready = 1'b0;
        send_req(1'b0, 16'h0020, 16'h0, 4'd1, 1'b0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        d0 = rsp_data; l0 = rsp_last;
        checks++;
        if (rsp_valid !== 1'b1 || d0 !== ref_rd(16'h0020) || l0 !== 1'b0) begin
            errors++; $display("FAIL bp_first v=%b d=%h l=%b expected 1 %h 0", rsp_valid, d0, l0, ref_rd(16'h0020));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_last !== l0 || mem_readMem !== 1'b0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_stall%0d v=%b d=%h l=%b rd=%b rr=%b expected 1 %h %b 0 0",
                                   i, rsp_valid, rsp_data, rsp_last, mem_readMem, req_ready, d0, l0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (mem_readMem !== 1'b1 || mem_address !== 16'h0021 || req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_next rd=%b a=%h rr=%b expected 1 0021 0", mem_readMem, mem_address, req_ready);
        end
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== ref_rd(16'h0021) || rsp_last !== 1'b1) begin
            errors++; $display("FAIL bp_second v=%b d=%h l=%b expected 1 %h 1", rsp_valid, rsp_data, rsp_last, ref_rd(16'h0021));
        end
        ack_rsp();
    endtask

    task automatic test_timeout();
        int cyc = -1;
        int pulses;
        model_dead = 1'b1;
        rsp_ready = 1'b0;
        send_req(1'b0, 16'h0040, 16'h0, 4'd3, 1'b0);
        pulses = mem_readMem ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_readMem) pulses++;
            if (rsp_valid) begin cyc = k; break; end
        end
        checks++;
        if (cyc != TIMEOUT + 1 || rsp_err !== 1'b1 || rsp_last !== 1'b1 || rsp_data !== 16'h0) begin
            errors++; $display("FAIL timeout_rsp cycle=%0d e=%b l=%b d=%h expected %0d 1 1 0000",
                               cyc, rsp_err, rsp_last, rsp_data, TIMEOUT + 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cyc = 0;
        for (int k = 0; k < 25; k++) begin
            if (rsp_valid) cyc++;
            if (mem_readMem) pulses++;
            @(negedge clk);
        end
        checks++;
        if (cyc != 0 || pulses != 1 || req_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_after extra_rsp=%0d strobes=%0d rr=%b expected 0 1 1", cyc, pulses, req_ready);
        end
        model_dead = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int stray = 0;
        model_dead = 1'b1;
        send_req(1'b0, 16'h0050, 16'h0, 4'd3, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_readMem, mem_wren, mem_address, mem_data, rsp_valid, rsp_data, rsp_last, rsp_err, busy} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs rd=%b a=%h v=%b busy=%b expected all 0",
                               mem_readMem, mem_address, rsp_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_dead = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_release rr=%b busy=%b expected 1 0", req_ready, busy);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid || mem_readMem) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rst_mid_stray activity=%0d expected 0", stray); end
    endtask

    task automatic test_back_to_back();
        bit drv_done = 1'b0;
        exp_q.delete();
        rand_lat = 1'b1;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [15:0] base;
                    base = ($urandom_range(0, 1) != 0) ? 16'hFFFC : 16'h0000;
                    send_req(n[0] == 1'b0, base + 16'($urandom_range(0, 7)), 16'($urandom),
                             4'($urandom_range(0, 3)), 1'b1);
                end
                req_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                for (int c = 0; c < 6000; c++) begin
                    beat_t e;
                    @(negedge clk);
                    rsp_ready = ($urandom_range(0, 1) != 0);
                    checks++;
                    if ((rsp_valid && req_ready) || (busy === req_ready)) begin
                        errors++; $display("FAIL b2b_ready rr=%b busy=%b v=%b", req_ready, busy, rsp_valid);
                    end
                    if (rsp_valid && rsp_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL b2b_extra got d=%h with nothing expected", rsp_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (rsp_data !== e.d || rsp_last !== e.last || rsp_err !== 1'b0) begin
                                errors++; $display("FAIL b2b_rsp d=%h l=%b e=%b expected %h %b 0",
                                                   rsp_data, rsp_last, rsp_err, e.d, e.last);
                            end
                        end
                    end
                    if (drv_done && exp_q.size() == 0 && !rsp_valid) break;
                end
                rsp_ready = 1'b0;
            end
        join
        checks++;
        if (exp_q.size() != 0 || clash) begin
            errors++; $display("FAIL b2b_end pending=%0d clash=%b expected 0 0", exp_q.size(), clash);
        end
        rand_lat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_backpressure();
        test_timeout();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
